chaotic_map_gen: RTL and testbench
==================================

# chaotic_map_gen

Sequential logistic-map generator producing the Q8.8 `chaotic_value` stream that the threshold comparator turns into `chaos_bit`.
- Iterates x(n+1) = R·x(n)·(1−x(n)) using one shared 16-cycle shift-add multiplier.
- Presents each new sample on a valid/ready handshake.
- Sits directly upstream of the comparator in the chaotic-LFSR datapath.

## Interface
- `R_Q88`, 16'h0300, map coefficient r in Q8.8 (legal 16'h0000..16'h0400).
- `SEED`, 16'h0080, reset value of internal state x, Q8.8 in [0,1).
- `clk`  input  1  clock, all state on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `en`  input  1  request next iteration (level, sampled in IDLE and on handshake edge).
- `seed_load`  input  1  load `seed_in` into x, abort any iteration.
- `seed_in`  input  16  new seed, Q8.8.
- `ready`  input  1  downstream accepts `chaotic_value`.
- `chaotic_value`  output  16  latest sample, Q8.8, always in 16'h0000..16'h00FF.
- `valid`  output  1  `chaotic_value` holds an unconsumed sample.
- `busy`  output  1  high in MUL1/MUL2.

## Operation
- Reset values: state=IDLE, x=SEED, `chaotic_value`=16'h0000, `valid`=0, `busy`=0, multiplier cleared.
- States and transitions:
  - IDLE: `en`=1 → MUL1.
  - MUL1: operands x and (16'h0100 − x); 16 cycles → t = P[23:8].
  - MUL2: operands R_Q88 and t; 16 cycles → raw y = P[23:8].
  - OUT: `valid`=1. On `valid`&&`ready`: x ← y; next state is MUL1 if `en`=1, else IDLE.
- Arithmetic:
  - Products are unsigned 32 bit; the Q8.8 result is bits [23:8], truncated with no rounding.
  - Upper clamp: y ≥ 16'h0100 → 16'h00FF.
- `chaotic_value` and x are both updated at OUT entry with the clamped (and, if enabled, escaped) y. `chaotic_value` is stable while `valid`=1.
- `seed_load` has priority over everything, in any state:
  - Loads x ← `seed_in`, clamped to 16'h00FF if ≥ 16'h0100.
  - Next state IDLE, `valid`=0, `busy`=0, multiplier cleared.
  - `chaotic_value` is held.
- `seed_load` coincident with a handshake: load wins, the sample counts as consumed, and the computed y is discarded.
- `en` is ignored outside IDLE and the handshake edge. Deasserting `en` mid-iteration does not abort it.
- Asserting `rst` mid-iteration returns all outputs to their reset values immediately.

## Timing
- Latency: `valid` rises 33 edges after the edge sampling `en`=1 in IDLE (1 transition, 16 MUL1, 16 MUL2).
- Throughput: with `en`=`ready`=1 held, one sample per 33 cycles. The handshake edge doubles as the MUL1 start edge.
- Backpressure: `valid` holds indefinitely while `ready`=0. No new iteration starts.
- `busy` is high exactly during the 32 multiply cycles.
- `valid` falls on the edge after handshake.
- No combinational path from inputs to outputs.

## Configuration
- `CHAOS_ESCAPE_EN`
  - Defined: after clamping, if y == 16'h0000 or y == x, replace y with ((x ^ 16'h00A5) | 16'h0001) & 16'h00FF. The result is always nonzero and ≠ x, which breaks the zero and fixed-point traps.
  - Undefined: y used as clamped. The generator may lock at 0 or at a fixed point.

## Test plan
- Reset, R_Q88=16'h0300, SEED=16'h0080, `en`=`ready`=1 → after 33 edges `valid`=1, `chaotic_value`=16'h00C0; next sample 33 cycles later =16'h0090.
- R_Q88=16'h0400, `seed_load` seed_in=16'h0080 → first sample 16'h00FF (clamped from 16'h0100). Second sample 16'h005B with `CHAOS_ESCAPE_EN`, 16'h0000 without. Without the macro, all later samples stay 16'h0000.
- `ready`=0 for 50 cycles after `valid` → `valid` and `chaotic_value` stable, `busy`=0. Raise `ready` → `valid` drops next edge; new iteration starts.
- `seed_load` with seed_in=16'h0040 at cycle 10 of MUL2 → next edge `busy`=0, state IDLE, `chaotic_value` unchanged. Next sample with R=16'h0300 is 16'h0090.
- seed_in=16'h0200 → x loads 16'h00FF. With R=16'h0300, raw y=0: first sample is 16'h0000 without the macro and 16'h005B with it.
- `rst` pulse asynchronously mid-MUL1 → `valid`, `busy`, `chaotic_value` at 0 before next edge. After release, x=SEED.

Source files
------------

// File: rtl/chaotic_map_gen.sv
// chaotic_map_gen
// Logistic-map generator x(n+1) = R * x(n) * (1 - x(n)) in Q8.8.
// One 16-cycle shift-add multiplier is shared by the two products of each iteration.
// Each sample is offered on a valid/ready handshake.
// Optional macro CHAOS_ESCAPE_EN: when the result is zero or equals x,
// replace it with a nonzero value that differs from x.

module chaotic_map_gen #(
    parameter logic [15:0] R_Q88 = 16'h0300,
    parameter logic [15:0] SEED  = 16'h0080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        seed_load,
    input  logic [15:0] seed_in,
    input  logic        ready,
    output logic [15:0] chaotic_value,
    output logic        valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        MUL1,
        MUL2,
        OUT
    } state_t;

    state_t      state;
    logic [15:0] x;
    logic [31:0] mcand;
    logic [15:0] mplier;
    logic [31:0] acc;
    logic [3:0]  step;

    logic [31:0] acc_next;
    logic [15:0] prod_q88;
    logic [15:0] y_clamped;
    logic [15:0] y_final;
    logic [15:0] seed_clamped;
    logic [15:0] one_minus_x;
    logic        unused_prod_bits;

    // One shift-add step, the truncated Q8.8 view of the product, and result shaping
    always_comb begin
        acc_next     = acc + (mplier[0] ? mcand : 32'd0);
        prod_q88     = acc_next[23:8];
        y_clamped    = (prod_q88 >= 16'h0100) ? 16'h00FF : prod_q88;
        seed_clamped = (seed_in >= 16'h0100) ? 16'h00FF : seed_in;
        one_minus_x  = 16'h0100 - x;
`ifdef CHAOS_ESCAPE_EN
        if ((y_clamped == 16'h0000) || (y_clamped == x)) begin
            y_final = ((x ^ 16'h00A5) | 16'h0001) & 16'h00FF;
        end else begin
            y_final = y_clamped;
        end
`else
        y_final = y_clamped;
`endif
    end

    assign unused_prod_bits = ^{acc_next[31:24], acc_next[7:0]};

    // Iteration sequencer: IDLE -> MUL1 (x*(1-x)) -> MUL2 (R*t) -> OUT, with seed_load overriding all
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            x             <= SEED;
            chaotic_value <= 16'h0000;
            valid         <= 1'b0;
            busy          <= 1'b0;
            mcand         <= 32'd0;
            mplier        <= 16'd0;
            acc           <= 32'd0;
            step          <= 4'd0;
        end else if (seed_load) begin
            state  <= IDLE;
            x      <= seed_clamped;
            valid  <= 1'b0;
            busy   <= 1'b0;
            mcand  <= 32'd0;
            mplier <= 16'd0;
            acc    <= 32'd0;
            step   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state  <= MUL1;
                        busy   <= 1'b1;
                        mcand  <= {16'h0000, x};
                        mplier <= one_minus_x;
                        acc    <= 32'd0;
                        step   <= 4'd0;
                    end
                end
                MUL1: begin
                    if (step == 4'd15) begin
                        state  <= MUL2;
                        mcand  <= {16'h0000, R_Q88};
                        mplier <= prod_q88;
                        acc    <= 32'd0;
                        step   <= 4'd0;
                    end else begin
                        acc    <= acc_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        step   <= step + 4'd1;
                    end
                end
                MUL2: begin
                    if (step == 4'd15) begin
                        state         <= OUT;
                        busy          <= 1'b0;
                        valid         <= 1'b1;
                        x             <= y_final;
                        chaotic_value <= y_final;
                        mcand         <= 32'd0;
                        mplier        <= 16'd0;
                        acc           <= 32'd0;
                        step          <= 4'd0;
                    end else begin
                        acc    <= acc_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        step   <= step + 4'd1;
                    end
                end
                OUT: begin
                    if (ready) begin
                        valid <= 1'b0;
                        if (en) begin
                            state  <= MUL1;
                            busy   <= 1'b1;
                            mcand  <= {16'h0000, x};
                            mplier <= one_minus_x;
                            acc    <= 32'd0;
                            step   <= 4'd0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chaotic_map_gen.sv
// tb_chaotic_map_gen
// Scoreboard bench for chaotic_map_gen: stimulus pushes hand-computed samples
// into a queue, and a monitor pops and compares them whenever a handshake is presented.
// One instance runs with R=3.0 and a second one with R=4.0 for the clamp cases.

module tb_chaotic_map_gen;

    logic        clk;
    logic        rst;
    logic        en, seed_load, ready;
    logic [15:0] seed_in;
    logic [15:0] chaotic_value;
    logic        valid, busy;
    logic        en4, seed_load4, ready4;
    logic [15:0] seed_in4;
    logic [15:0] chaotic_value4;
    logic        valid4, busy4;

    int tests_run;
    int tests_failed;
    logic [15:0] exp_q[$];
    logic [15:0] exp_q4[$];

    chaotic_map_gen #(.R_Q88(16'h0300), .SEED(16'h0080)) dut (
        .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
        .ready(ready), .chaotic_value(chaotic_value), .valid(valid), .busy(busy)
    );

    chaotic_map_gen #(.R_Q88(16'h0400), .SEED(16'h0080)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .seed_load(seed_load4), .seed_in(seed_in4),
        .ready(ready4), .chaotic_value(chaotic_value4), .valid(valid4), .busy(busy4)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic sl, input logic [15:0] si, input logic r);
        en        = e;
        seed_load = sl;
        seed_in   = si;
        ready     = r;
    endtask

    task automatic waitValid(input bit use4, input string name);
        int cycles;
        cycles = 0;
        while (!(use4 ? valid4 : valid) && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput({name, "_timeout"}, 32'(cycles >= 100), 32'd0);
    endtask

    // Monitor for the R=3.0 instance: compare each offered sample with the scoreboard head
    always @(negedge clk) begin
        if (!rst && valid && ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_sample", 32'(chaotic_value), 32'hFFFF_FFFF);
            end else begin
                checkOutput("sample", 32'(chaotic_value), 32'(exp_q.pop_front()));
            end
        end
    end

    // Monitor for the R=4.0 instance
    always @(negedge clk) begin
        if (!rst && valid4 && ready4) begin
            if (exp_q4.size() == 0) begin
                checkOutput("unexpected_sample4", 32'(chaotic_value4), 32'hFFFF_FFFF);
            end else begin
                checkOutput("sample4", 32'(chaotic_value4), 32'(exp_q4.pop_front()));
            end
        end
    end

    // Watchdog so a stuck design still terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests_run, tests_failed);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int bad;
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        en4 = 1'b0; seed_load4 = 1'b0; seed_in4 = 16'h0000; ready4 = 1'b0;

        // Reset values
        #3;
        checkOutput("rst_valid", 32'(valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_value", 32'(chaotic_value), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Latency and throughput from SEED=0x80, R=3.0: 0xC0 then 0x90
        exp_q.push_back(16'h00C0);
        exp_q.push_back(16'h0090);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
        repeat (32) @(posedge clk);
        #1;
        checkOutput("lat_valid_early", 32'(valid), 32'd0);
        checkOutput("lat_busy_mid", 32'(busy), 32'd1);
        @(posedge clk); #1;
        checkOutput("lat_valid_33", 32'(valid), 32'd1);
        checkOutput("lat_busy_out", 32'(busy), 32'd0);
        repeat (32) @(posedge clk);
        #1;
        checkOutput("thr_valid_early", 32'(valid), 32'd0);
        checkOutput("thr_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        checkOutput("thr_valid_33", 32'(valid), 32'd1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        @(posedge clk); #1;
        checkOutput("idle_valid", 32'(valid), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        // Backpressure: x=0x90 gives 0xBD, held while ready is low
        exp_q.push_back(16'h00BD);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        waitValid(1'b0, "bp");
        bad = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (!(valid === 1'b1 && chaotic_value === 16'h00BD && busy === 1'b0)) bad++;
        end
        checkOutput("bp_stable", 32'(bad), 32'd0);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
        @(posedge clk); #1;
        checkOutput("bp_release_valid", 32'(valid), 32'd0);
        checkOutput("bp_release_busy", 32'(busy), 32'd1);

        // seed_load at cycle 10 of MUL2 aborts; the held value stays 0xBD
        repeat (25) @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b1, 16'h0040, 1'b1);
        @(posedge clk); #1;
        checkOutput("load_busy", 32'(busy), 32'd0);
        checkOutput("load_valid", 32'(valid), 32'd0);
        checkOutput("load_value_held", 32'(chaotic_value), 32'h00BD);
        exp_q.push_back(16'h0090);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
        waitValid(1'b0, "seed40");
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of MUL1
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        repeat (5) @(posedge clk);
        #3;
        checkOutput("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("arst_valid", 32'(valid), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_value", 32'(chaotic_value), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back(16'h00C0);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
        waitValid(1'b0, "after_rst");
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        @(posedge clk); #1;

        // Oversized seed clamps to 0xFF; with R=3.0 the raw result is 0
        applyStimulus(1'b0, 1'b1, 16'h0200, 1'b1);
        @(posedge clk); #1;
`ifdef CHAOS_ESCAPE_EN
        exp_q.push_back(16'h005B);
`else
        exp_q.push_back(16'h0000);
`endif
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
        waitValid(1'b0, "seed200");
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        @(posedge clk); #1;

        // R=4.0 from 0x80: clamp to 0xFF, then zero trap or escape
        seed_load4 = 1'b1;
        seed_in4   = 16'h0080;
        @(posedge clk); #1;
        seed_load4 = 1'b0;
        exp_q4.push_back(16'h00FF);
`ifdef CHAOS_ESCAPE_EN
        exp_q4.push_back(16'h005B);
        exp_q4.push_back(16'h00E8);
`else
        exp_q4.push_back(16'h0000);
        exp_q4.push_back(16'h0000);
`endif
        en4    = 1'b1;
        ready4 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            waitValid(1'b1, "r4");
            if (k == 2) en4 = 1'b0;
            @(posedge clk); #1;
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("scoreboard4_drained", 32'(exp_q4.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
